// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared types and constants for the command-link response path
package comm_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ACK_HDR_DFLT  = 8'hA5;
  localparam logic [BYTE_W-1:0] NACK_HDR_DFLT = 8'h5A;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    CMD     = 3'd2,
    LEN     = 3'd3,
    PAYLOAD = 3'd4,
    CHK     = 3'd5,
    DONE    = 3'd6
  } tx_state_t;

endpackage

// File: rtl/ack_transmitter.sv
// rtl/ack_transmitter.sv - frames ACK/NACK responses (HDR CMD LEN PAYLOAD CHK) onto a valid/ready byte link
module ack_transmitter
  import comm_pkg::*;
#(
  parameter int                MAX_PAYLOAD = 4,
  parameter logic [BYTE_W-1:0] ACK_HDR     = ACK_HDR_DFLT,
  parameter logic [BYTE_W-1:0] NACK_HDR    = NACK_HDR_DFLT,
  parameter int                LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          send_ack,
  input  logic                          nack,
  input  logic [BYTE_W-1:0]             cmd_code,
  input  logic [BYTE_W*MAX_PAYLOAD-1:0] payload,
  input  logic [LEN_W-1:0]              payload_len,
  output logic [BYTE_W-1:0]             tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          dropped
);

  tx_state_t                     r_state;
  tx_state_t                     w_next;
  logic                          r_nack;
  logic [BYTE_W-1:0]             r_cmd;
  logic [BYTE_W*MAX_PAYLOAD-1:0] r_payload;
  logic [LEN_W-1:0]              r_len;
  logic [LEN_W-1:0]              r_idx;
  logic [BYTE_W-1:0]             r_chk;
  logic                          r_dropped;

  logic              w_capture;
  logic              w_xfer;
  logic              w_last;
  logic [LEN_W-1:0]  w_len_clamped;
  logic [BYTE_W-1:0] w_pay_byte;

  assign w_capture     = (r_state == IDLE) && send_ack;
  assign w_xfer        = tx_valid && tx_ready;
  assign w_last        = (r_idx == r_len - LEN_W'(1));
  assign w_len_clamped = (payload_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : payload_len;

  always_comb begin
    w_pay_byte = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (r_idx == LEN_W'(i)) w_pay_byte = r_payload[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (send_ack) w_next = HDR;
      HDR:     if (w_xfer) w_next = CMD;
      CMD:     if (w_xfer) w_next = LEN;
      LEN:     if (w_xfer) w_next = (r_len != '0) ? PAYLOAD : CHK;
      PAYLOAD: if (w_xfer && w_last) w_next = CHK;
      CHK:     if (w_xfer) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      HDR: begin
        tx_data  = r_nack ? NACK_HDR : ACK_HDR;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      CMD: begin
        tx_data  = r_cmd;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      LEN: begin
        tx_data  = {{(BYTE_W-LEN_W){1'b0}}, r_len};
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      PAYLOAD: begin
        tx_data  = w_pay_byte;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      CHK: begin
        tx_data  = r_chk;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Checksum folds in every byte except itself, so CHK presents the running XOR as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nack    <= 1'b0;
      r_cmd     <= '0;
      r_payload <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_chk     <= '0;
    end else if (w_capture) begin
      r_nack    <= nack;
      r_cmd     <= cmd_code;
      r_payload <= payload;
      r_len     <= w_len_clamped;
      r_idx     <= '0;
      r_chk     <= '0;
    end else if (w_xfer) begin
      if (r_state != CHK)     r_chk <= r_chk ^ tx_data;
      if (r_state == PAYLOAD) r_idx <= r_idx + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dropped <= 1'b0;
    else        r_dropped <= send_ack && (r_state != IDLE);
  end

  assign dropped = r_dropped;

endmodule

// File: tb/tb_ack_transmitter.sv
// tb/tb_ack_transmitter.sv - directed self-checking bench for ack_transmitter
module tb_ack_transmitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send_ack;
  logic        nack;
  logic [7:0]  cmd_code;
  logic [31:0] payload;
  logic [2:0]  payload_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        dropped;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         n_busy;
  int         n_drop;
  int         done_gap;

  always #5 clk = ~clk;

  ack_transmitter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send_ack    (send_ack),
    .nack        (nack),
    .cmd_code    (cmd_code),
    .payload     (payload),
    .payload_len (payload_len),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .dropped     (dropped)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic n, input logic [7:0] cmd, input logic [31:0] pl, input logic [2:0] len);
    send_ack    = 1'b1;
    nack        = n;
    cmd_code    = cmd;
    payload     = pl;
    payload_len = len;
    @(negedge clk);
    send_ack    = 1'b0;
    nack        = ~n;
    cmd_code    = 8'hFF;
    payload     = 32'hDEAD_BEEF;
    payload_len = 3'd1;
  endtask

  // Collects one frame up to the DONE cycle; stall = idle cycles of tx_ready before each accept.
  task automatic collect(input int stall, input int inject_at);
    int   s = 0;
    int   since = 0;
    bit   finished = 0;
    bit   stalled = 0;
    bit   rdy;
    logic [7:0] prev = 8'h00;
    got.delete();
    n_busy = 0;
    n_drop = 0;
    done_gap = -1;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (dropped) n_drop++;
      if (done) begin
        finished = 1;
        done_gap = since;
      end else begin
        if (busy) n_busy++;
        if (stalled) begin
          chk_eq("hold_valid", {31'd0, tx_valid}, 32'd1);
          chk_eq("hold_data", {24'd0, tx_data}, {24'd0, prev});
        end
        rdy = tx_valid && (s >= stall);
        if (tx_valid) begin
          if (rdy) begin
            got.push_back(tx_data);
            s = 0;
          end else s++;
        end
        stalled  = tx_valid && !rdy;
        prev     = tx_data;
        tx_ready = rdy;
        send_ack = (cyc == inject_at);
        if (cyc == inject_at) begin
          nack     = 1'b1;
          cmd_code = 8'hEE;
          payload_len = 3'd0;
        end
        if (rdy) since = 0;
        @(negedge clk);
        since++;
      end
    end
    chk_eq("frame_finished", {31'd0, finished}, 32'd1);
    tx_ready = 1'b0;
    send_ack = 1'b0;
  endtask

  task automatic chk_frame(input string tag);
    chk_eq({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk_eq($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    send_ack = 1'b0;
    nack = 1'b0;
    cmd_code = 8'h00;
    payload = 32'h0;
    payload_len = 3'd0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk_eq("rst_data", {24'd0, tx_data}, 32'd0);
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_done", {31'd0, done}, 32'd0);
    chk_eq("rst_dropped", {31'd0, dropped}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ACK, two payload bytes, full rate
    send_req(1'b0, 8'h12, 32'h0000_5634, 3'd2);
    chk_eq("t1_first_valid", {31'd0, tx_valid}, 32'd1);
    chk_eq("t1_first_hdr", {24'd0, tx_data}, 32'hA5);
    collect(0, -1);
    exp_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'hD7};
    chk_frame("t1");
    chk_eq("t1_busy_cycles", n_busy, 6);
    chk_eq("t1_done_gap", done_gap, 1);
    chk_eq("t1_no_drop", n_drop, 0);
    @(negedge clk);
    chk_eq("t1_done_pulse", {31'd0, done}, 32'd0);

    // 2: NACK, empty payload
    send_req(1'b1, 8'h07, 32'h1122_3344, 3'd0);
    collect(0, -1);
    exp_q = '{8'h5A, 8'h07, 8'h00, 8'h5D};
    chk_frame("t2");
    chk_eq("t2_busy_cycles", n_busy, 4);
    @(negedge clk);

    // 3: scenario 1 under 0,0,1 backpressure
    send_req(1'b0, 8'h12, 32'h0000_5634, 3'd2);
    collect(2, -1);
    exp_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'hD7};
    chk_frame("t3");
    chk_eq("t3_busy_cycles", n_busy, 18);
    chk_eq("t3_done_gap", done_gap, 1);
    @(negedge clk);

    // 4: length clamp plus a request injected mid-frame
    send_req(1'b0, 8'h20, 32'h4433_2211, 3'd7);
    collect(0, 2);
    exp_q = '{8'hA5, 8'h20, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC5};
    chk_frame("t4");
    chk_eq("t4_dropped_once", n_drop, 1);
    @(negedge clk);

    // 5: reset during PAYLOAD, then a fresh frame
    send_req(1'b0, 8'h12, 32'h0000_5634, 3'd2);
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("t5_in_payload", {24'd0, tx_data}, 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("t5_rst_done", {31'd0, done}, 32'd0);
    tx_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("t5_idle_after", {31'd0, tx_valid}, 32'd0);
    send_req(1'b1, 8'h07, 32'h0, 3'd0);
    collect(1, -1);
    exp_q = '{8'h5A, 8'h07, 8'h00, 8'h5D};
    chk_frame("t5");

    // 6: back-to-back; collect returns in the DONE cycle
    send_ack    = 1'b1;
    nack        = 1'b1;
    cmd_code    = 8'h77;
    payload_len = 3'd0;
    @(negedge clk);
    chk_eq("t6_dropped_in_done", {31'd0, dropped}, 32'd1);
    chk_eq("t6_idle_valid", {31'd0, tx_valid}, 32'd0);
    send_req(1'b0, 8'h99, 32'h0000_0001, 3'd1);
    chk_eq("t6_hdr_valid", {31'd0, tx_valid}, 32'd1);
    chk_eq("t6_hdr_data", {24'd0, tx_data}, 32'hA5);
    chk_eq("t6_no_drop", {31'd0, dropped}, 32'd0);
    collect(0, -1);
    exp_q = '{8'hA5, 8'h99, 8'h01, 8'h01, 8'h3C};
    chk_frame("t6");
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
